rf_writeback_queue: RTL and testbench

Write-side initiator for the 32×32 register file. It collects writeback results from the ALU and load/store unit, buffers them in a small in-order FIFO and drains at most one entry per cycle onto the register-file write port (WE3/A3/WD3). It also reports, per read address, whether a write to that register is still pending, so issue logic can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

---
 rtl/rf_writeback_queue_if.sv | 45 ++++
 rtl/rf_writeback_queue.sv | 118 +++++++++++
 tb/tb_rf_writeback_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Writeback request, hazard query and register-file write port bundle.
// master: the side producing writeback requests and consuming the write port.
// slave:  the writeback queue itself.
interface rf_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic [4:0]      A1;
  logic [4:0]      A2;
  logic            busy1;
  logic            busy2;

  logic            WE3;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
  logic [CW-1:0]   count;

  modport master (
    output lsu_valid, lsu_rd, lsu_data,
    output alu_valid, alu_rd, alu_data,
    output A1, A2,
    input  lsu_ready, alu_ready, busy1, busy2,
    input  WE3, A3, WD3, count
  );

  modport slave (
    input  lsu_valid, lsu_rd, lsu_data,
    input  alu_valid, alu_rd, alu_data,
    input  A1, A2,
    output lsu_ready, alu_ready, busy1, busy2,
    output WE3, A3, WD3, count
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the register-file write port.
// Accepts up to two results per cycle (LSU first, ALU second), drains one per
// cycle onto WE3/A3/WD3 and flags reads that hit a still-pending write.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               areset,
  rf_writeback_queue_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FREE_ONE = (CW+1)'(1);
  localparam logic [CW:0] FREE_TWO = (CW+1)'(2);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic            we3_q, we3_d;
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;

  logic            pop;
  logic [CW:0]     free;
  logic            lsu_ready, alu_ready;
  logic            lsu_push, alu_push;
  logic [PW-1:0]   alu_slot;
  logic [CW-1:0]   n_push;

  logic [PW-1:0]   off;
  logic            hit1, hit2;

  // Admission: the entry popped this cycle frees a slot for incoming requests.
  always_comb begin
    pop       = (count_q != '0);
    free      = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    lsu_ready = !areset && (free >= FREE_ONE);
    lsu_push  = wb.lsu_valid && lsu_ready && (wb.lsu_rd != 5'd0);
    alu_ready = !areset && ((free >= FREE_TWO) || ((free >= FREE_ONE) && !lsu_push));
    alu_push  = wb.alu_valid && alu_ready && (wb.alu_rd != 5'd0);
    alu_slot  = wr_ptr_q + PW'(lsu_push);
    n_push    = CW'(lsu_push) + CW'(alu_push);
    count_d   = count_q + n_push - CW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(n_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
  end

  // Drain stage: present the head for one cycle, hold address/data when idle.
  always_comb begin
    we3_d = pop;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (pop) begin
      a3_d  = rd_mem_q[rd_ptr_q];
      wd3_d = data_mem_q[rd_ptr_q];
    end
  end

  // Hazard lookup over occupied entries plus the write currently on the port.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (rd_mem_q[i] == wb.A1) hit1 = 1'b1;
        if (rd_mem_q[i] == wb.A2) hit2 = 1'b1;
      end
    end
    if (we3_q && (a3_q == wb.A1)) hit1 = 1'b1;
    if (we3_q && (a3_q == wb.A2)) hit2 = 1'b1;
  end

  // Pointer, occupancy and write-port registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Entry storage; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      rd_mem_q[wr_ptr_q]   <= wb.lsu_rd;
      data_mem_q[wr_ptr_q] <= wb.lsu_data;
    end
    if (alu_push) begin
      rd_mem_q[alu_slot]   <= wb.alu_rd;
      data_mem_q[alu_slot] <= wb.alu_data;
    end
  end

  assign wb.lsu_ready = lsu_ready;
  assign wb.alu_ready = alu_ready;
  assign wb.busy1     = (wb.A1 != 5'd0) && hit1;
  assign wb.busy2     = (wb.A2 != 5'd0) && hit2;
  assign wb.WE3       = we3_q;
  assign wb.A3        = a3_q;
  assign wb.WD3       = wd3_q;
  assign wb.count     = count_q;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the writeback path.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  rf_writeback_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) wb ();
  rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .areset(areset),
    .wb    (wb)
  );

  ent_t            mq[$];
  logic            m_we;
  logic [4:0]      m_a3;
  logic [XLEN-1:0] m_wd3;
  logic [XLEN-1:0] rf_m [32];
  logic [XLEN-1:0] rf_d [32];
  logic            e_lrdy, e_ardy;
  int              total = 0;
  int              bad   = 0;
  logic            saw_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return m_we && (m_a3 == a);
  endfunction

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                       input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb.lsu_valid = lv;  wb.lsu_rd = lrd;  wb.lsu_data = ld;
    wb.alu_valid = av;  wb.alu_rd = ard;  wb.alu_data = ad;
    wb.A1 = a1;  wb.A2 = a2;
  endtask

  task automatic check_state(input string tag);
    int   free;
    logic lpush;
    free = DEPTH - mq.size() + ((mq.size() != 0) ? 1 : 0);
    if (areset) begin
      e_lrdy = 1'b0;
      e_ardy = 1'b0;
    end else begin
      e_lrdy = (free >= 1);
      lpush  = wb.lsu_valid && e_lrdy && (wb.lsu_rd != 5'd0);
      e_ardy = (free >= 2) || ((free >= 1) && !lpush);
    end
    chk({tag, ":lsu_ready"}, 64'(wb.lsu_ready), 64'(e_lrdy));
    chk({tag, ":alu_ready"}, 64'(wb.alu_ready), 64'(e_ardy));
    chk({tag, ":busy1"}, 64'(wb.busy1), 64'(pending(wb.A1)));
    chk({tag, ":busy2"}, 64'(wb.busy2), 64'(pending(wb.A2)));
    chk({tag, ":count"}, 64'(wb.count), 64'(mq.size()));
    chk({tag, ":WE3"}, 64'(wb.WE3), 64'(m_we));
    chk({tag, ":A3"}, 64'(wb.A3), 64'(m_a3));
    chk({tag, ":WD3"}, 64'(wb.WD3), 64'(m_wd3));
    chk({tag, ":count_le_depth"}, 64'(wb.count <= 3'(DEPTH)), 64'(1));
    if (wb.lsu_ready && !wb.alu_ready && wb.lsu_valid && (wb.lsu_rd != 5'd0)) saw_drop = 1'b1;
    if (wb.WE3) rf_d[wb.A3] = wb.WD3;
  endtask

  task automatic advance_model(input logic lacc, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                               input logic aacc, input logic [4:0] ard, input logic [XLEN-1:0] ad);
    ent_t e;
    if (m_we) rf_m[m_a3] = m_wd3;
    if (mq.size() != 0) begin
      e     = mq.pop_front();
      m_we  = 1'b1;
      m_a3  = e.rd;
      m_wd3 = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (lacc && (lrd != 5'd0)) mq.push_back('{rd: lrd, data: ld});
    if (aacc && (ard != 5'd0)) mq.push_back('{rd: ard, data: ad});
  endtask

  task automatic cycle(input string tag,
                       input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                       input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic [4:0] a1, input logic [4:0] a2);
    logic la, aa;
    drive(lv, lrd, ld, av, ard, ad, a1, a2);
    #1;
    check_state(tag);
    la = lv && e_lrdy;
    aa = av && e_ardy;
    @(posedge clk);
    advance_model(la, lrd, ld, aa, ard, ad);
    #1;
  endtask

  task automatic idle(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    cycle(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, a1, a2);
  endtask

  // Pulse reset between clock edges with requests asserted; model is cleared.
  task automatic reset_mid(input string tag);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    #2;
    areset = 1'b1;
    #1;
    chk({tag, ":count"}, 64'(wb.count), 64'(0));
    chk({tag, ":WE3"}, 64'(wb.WE3), 64'(0));
    chk({tag, ":A3"}, 64'(wb.A3), 64'(0));
    chk({tag, ":WD3"}, 64'(wb.WD3), 64'(0));
    chk({tag, ":lsu_ready"}, 64'(wb.lsu_ready), 64'(0));
    chk({tag, ":alu_ready"}, 64'(wb.alu_ready), 64'(0));
    mq.delete();
    m_we  = 1'b0;
    m_a3  = '0;
    m_wd3 = '0;
    areset = 1'b0;
  endtask

  initial begin
    logic [4:0]      lrd, ard;
    logic [XLEN-1:0] ld, ad;
    for (int i = 0; i < 32; i++) begin
      rf_m[i] = '0;
      rf_d[i] = '0;
    end
    m_we = 1'b0;  m_a3 = '0;  m_wd3 = '0;
    saw_drop = 1'b0;
    areset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    #2;
    check_state("reset");
    #1;
    areset = 1'b0;

    // Single ALU write into an empty queue.
    cycle("t1_push", 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle("t1_n1", 5'd5, 5'd0);
    chk("t1_WE3", 64'(wb.WE3), 64'(1));
    chk("t1_A3", 64'(wb.A3), 64'(5));
    chk("t1_WD3", 64'(wb.WD3), 64'(32'hDEADBEEF));
    chk("t1_busy_inflight", 64'(wb.busy1), 64'(1));
    idle("t1_n2", 5'd5, 5'd0);
    chk("t1_busy_clear", 64'(wb.busy1), 64'(0));
    chk("t1_WE3_off", 64'(wb.WE3), 64'(0));

    // Same-cycle LSU and ALU writes to the same register.
    cycle("t2_push", 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 5'd7, 5'd0);
    idle("t2_d1", 5'd7, 5'd0);
    chk("t2_first", 64'(wb.WD3), 64'(1));
    idle("t2_d2", 5'd7, 5'd0);
    chk("t2_second", 64'(wb.WD3), 64'(2));
    idle("t2_d3", 5'd7, 5'd0);
    chk("t2_rf7", 64'(rf_d[7]), 64'(2));

    // x0 requests are acknowledged but never queued.
    cycle("t3_x0", 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 5'd0, 5'd0);
    chk("t3_count", 64'(wb.count), 64'(0));
    idle("t3_after", 5'd0, 5'd0);
    chk("t3_WE3", 64'(wb.WE3), 64'(0));

    // Continuous dual push into DEPTH=4, then drain.
    for (int i = 0; i < 8; i++) begin
      cycle("t4_fill", 1'b1, 5'(1 + 2 * i), 32'h100 + i, 1'b1, 5'(2 + 2 * i), 32'h200 + i,
            5'(1 + 2 * i), 5'd2);
    end
    chk("t4_alu_drop_seen", 64'(saw_drop), 64'(1));
    for (int i = 0; i < 6; i++) idle("t4_drain", 5'd15, 5'd16);

    // Reset while count=3 and WE3=1.
    cycle("t5_a", 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1, 5'd10, 5'd11);
    cycle("t5_b", 1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3, 5'd12, 5'd13);
    chk("t5_pre_count", 64'(wb.count), 64'(3));
    chk("t5_pre_WE3", 64'(wb.WE3), 64'(1));
    reset_mid("t5_rst");
    for (int i = 0; i < 4; i++) idle("t5_post", 5'd12, 5'd13);

    // Full queue with a pending pop still admits one LSU request.
    cycle("t6_f1", 1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2, 5'd0, 5'd0);
    cycle("t6_f2", 1'b1, 5'd3, 32'hB3, 1'b1, 5'd4, 32'hB4, 5'd0, 5'd0);
    cycle("t6_f3", 1'b1, 5'd5, 32'hB5, 1'b1, 5'd6, 32'hB6, 5'd0, 5'd0);
    chk("t6_full", 64'(wb.count), 64'(4));
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0, 5'd9, 5'd0);
    #1;
    chk("t6_lsu_ready", 64'(wb.lsu_ready), 64'(1));
    chk("t6_alu_ready", 64'(wb.alu_ready), 64'(0));
    @(negedge clk);
    cycle("t6_push9", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0, 5'd9, 5'd0);
    chk("t6_count_held", 64'(wb.count), 64'(4));
    for (int i = 0; i < 4; i++) idle("t6_drain", 5'd9, 5'd0);
    chk("t6_A3_is_9", 64'(wb.A3), 64'(9));
    chk("t6_WE3_for_9", 64'(wb.WE3), 64'(1));
    for (int i = 0; i < 2; i++) idle("t6_tail", 5'd9, 5'd0);

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_mid("rnd_rst");
      end else begin
        lrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ard = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ld  = $urandom;
        ad  = $urandom;
        cycle("rnd", 1'($urandom_range(0, 9) < 6), lrd, ld, 1'($urandom_range(0, 9) < 6), ard, ad,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    for (int i = 0; i < 8; i++) idle("final_drain", 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), 64'(rf_d[i]), 64'(rf_m[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
